// File: rtl/lei_pkg.sv
// ---------------------------------------------------------------------------
// lei_pkg
// Shared definitions for the logic-element interconnect crossbar:
//   lei_sel_w()      - width of one routing select field for a slot count
//   lei_field_off()  - bit offset of routing field f inside a config vector
//   lei_cfg_state_e  - configuration loader states (IDLE, SHIFTING, FULL)
//   LEI_DISABLE      - all-ones pattern; any field holding it is disabled
// ---------------------------------------------------------------------------
package lei_pkg;

  // One extra MSB above what is needed to name every slot, so that the
  // upper half of the code space is available as "not driven" codes.
  function automatic int lei_sel_w(input int num_slots);
    return $clog2(num_slots) + 1;
  endfunction

  function automatic int lei_field_off(input int field, input int sel_w);
    return field * sel_w;
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFTING = 2'd1,
    FULL     = 2'd2
  } lei_cfg_state_e;

  // Truncated to SEL_W by users; all-ones is always >= NUM_SLOTS.
  localparam logic [31:0] LEI_DISABLE = 32'hFFFF_FFFF;

endpackage : lei_pkg

// File: rtl/lei_route_mux.sv
// ---------------------------------------------------------------------------
// lei_route_mux
// One destination pin of the crossbar. Selects one LE output slot by its
// select code, or leaves the pin undriven when the code is a disable code.
//   sel    in  SEL_W      routing select; values >= NUM_SLOTS disable the pin
//   leout  in  NUM_SLOTS  LE output slots
//   lein   out 1          routed value (0 when disabled)
//   drv    out 1          1 when the pin is driven by the crossbar
// ---------------------------------------------------------------------------
module lei_route_mux
  import lei_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SEL_W     = lei_sel_w(NUM_SLOTS)
) (
  input  logic [SEL_W-1:0]     sel,
  input  logic [NUM_SLOTS-1:0] leout,
  output logic                 lein,
  output logic                 drv
);

  // Index bits: everything below the disable MSB.
  localparam int IDX_W = SEL_W - 1;
  localparam logic [SEL_W-1:0] SLOT_LIMIT = SEL_W'(NUM_SLOTS);

  logic sel_disabled;

  // Covers both the explicit disable codes (MSB set) and any unused
  // in-range codes when NUM_SLOTS is not a power of two.
  assign sel_disabled = (sel >= SLOT_LIMIT);

  always_comb begin
    lein = 1'b0;
    drv  = 1'b0;
    if (!sel_disabled) begin
      drv  = 1'b1;
      lein = leout[sel[IDX_W-1:0]];
    end
  end

endmodule : lei_route_mux

// File: rtl/lei_xbar_cfg.sv
// ---------------------------------------------------------------------------
// lei_xbar_cfg
// Logic-element interconnect crossbar with a double-buffered serial
// configuration. A scan chain fills a shadow register; a commit copies the
// shadow into the active register that drives the routing muxes. Routing
// stays live while the shadow is being reloaded.
//
// Ports:
//   clk, rst      fabric clock (rising edge), asynchronous active-high reset
//   en            tile enable; gates shift and commit
//   cfg_in        serial config data
//   cfg_shift     shift one config bit this cycle
//   cfg_commit    commit request (single-cycle pulse)
//   cfg_out       chain output = shadow bit 0, feeds the next tile
//   cfg_ready     shadow holds exactly CFG_BITS fresh bits
//   cfg_err       sticky: last commit request was rejected
//   active_valid  at least one commit accepted since reset
//   leout         LE output slots (slot s = LE s/OUTS_PER_LE)
//   lein          routed LE input pins, bit s*LE_INPUTS+k
//   drv           1 = matching lein bit is driven by the crossbar
//
// Build option:
//   LEI_OUT_REG_EN  when defined, lein/drv are registered (1 cycle from
//                   leout, 2 cycles from commit); otherwise combinational.
// ---------------------------------------------------------------------------
module lei_xbar_cfg
  import lei_pkg::*;
#(
  parameter int NUM_LE      = 2,
  parameter int OUTS_PER_LE = 2,
  parameter int LE_INPUTS   = 4,
  parameter int SEL_W       = lei_sel_w(NUM_LE * OUTS_PER_LE)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic                                      cfg_in,
  input  logic                                      cfg_shift,
  input  logic                                      cfg_commit,
  output logic                                      cfg_out,
  output logic                                      cfg_ready,
  output logic                                      cfg_err,
  output logic                                      active_valid,
  input  logic [NUM_LE*OUTS_PER_LE-1:0]             leout,
  output logic [NUM_LE*OUTS_PER_LE*LE_INPUTS-1:0]   lein,
  output logic [NUM_LE*OUTS_PER_LE*LE_INPUTS-1:0]   drv
);

  localparam int NUM_SLOTS  = NUM_LE * OUTS_PER_LE;
  localparam int NUM_FIELDS = NUM_SLOTS * LE_INPUTS;
  localparam int CFG_BITS   = NUM_FIELDS * SEL_W;
  localparam int CNT_W      = $clog2(CFG_BITS + 1);

  localparam logic [CNT_W-1:0]    CNT_MAX     = CNT_W'(CFG_BITS);
  localparam logic [SEL_W-1:0]    DIS_FIELD   = SEL_W'(LEI_DISABLE);
  localparam logic [CFG_BITS-1:0] CFG_DISABLE = {NUM_FIELDS{DIS_FIELD}};

  // -------------------------------------------------------------------------
  // Configuration state
  // -------------------------------------------------------------------------
  logic [CFG_BITS-1:0] shadow_reg;
  logic [CFG_BITS-1:0] active_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  lei_cfg_state_e      state_reg, state_next;
  logic                err_reg, err_next;
  logic                valid_reg;

  logic do_shift;
  logic commit_req;
  logic commit_ok;
  logic commit_rej;

  assign do_shift   = en & cfg_shift;
  assign commit_req = en & cfg_commit;
  // A commit that coincides with a shift would copy a half-updated shadow,
  // so it is refused; the shift still happens.
  assign commit_ok  = commit_req & ~cfg_shift & (state_reg == FULL);
  assign commit_rej = commit_req & ~commit_ok;

  // Next-state logic: the state simply tracks how many fresh bits the
  // shadow holds, and an accepted commit consumes them.
  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    err_next   = err_reg;

    if (commit_ok) begin
      cnt_next   = '0;
      state_next = IDLE;
      err_next   = 1'b0;
    end else begin
      if (commit_rej) begin
        err_next = 1'b1;
      end
      if (do_shift) begin
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
        state_next = (cnt_next == CNT_MAX) ? FULL : SHIFTING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg <= CFG_DISABLE;
      active_reg <= CFG_DISABLE;
      cnt_reg    <= '0;
      state_reg  <= IDLE;
      err_reg    <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      state_reg <= state_next;
      err_reg   <= err_next;
      if (do_shift) begin
        // New bits enter at the top and walk toward bit 0 / cfg_out.
        shadow_reg <= {cfg_in, shadow_reg[CFG_BITS-1:1]};
      end
      if (commit_ok) begin
        active_reg <= shadow_reg;
        valid_reg  <= 1'b1;
      end
    end
  end

  assign cfg_out      = shadow_reg[0];
  assign cfg_ready    = (state_reg == FULL);
  assign cfg_err      = err_reg;
  assign active_valid = valid_reg;

  // -------------------------------------------------------------------------
  // Routing muxes: one per destination pin, driven from the active copy only
  // -------------------------------------------------------------------------
  logic [NUM_FIELDS-1:0] lein_comb;
  logic [NUM_FIELDS-1:0] drv_comb;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FIELDS; gi++) begin : g_pin
      localparam int FIELD_OFF = lei_field_off(gi, SEL_W);

      lei_route_mux #(
        .NUM_SLOTS (NUM_SLOTS),
        .SEL_W     (SEL_W)
      ) u_mux (
        .sel   (active_reg[FIELD_OFF +: SEL_W]),
        .leout (leout),
        .lein  (lein_comb[gi]),
        .drv   (drv_comb[gi])
      );
    end
  endgenerate

`ifdef LEI_OUT_REG_EN
  logic [NUM_FIELDS-1:0] lein_reg;
  logic [NUM_FIELDS-1:0] drv_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lein_reg <= '0;
      drv_reg  <= '0;
    end else begin
      lein_reg <= lein_comb;
      drv_reg  <= drv_comb;
    end
  end

  assign lein = lein_reg;
  assign drv  = drv_reg;
`else
  assign lein = lein_comb;
  assign drv  = drv_comb;
`endif

endmodule : lei_xbar_cfg

// File: tb/tb_lei_xbar_cfg.sv
// ---------------------------------------------------------------------------
// tb_lei_xbar_cfg
// Self-checking bench for lei_xbar_cfg at its default parameters
// (4 slots, 4 inputs per slot, 3-bit selects, 48 config bits).
// ---------------------------------------------------------------------------
module tb_lei_xbar_cfg;

  localparam int NF = 16;
  localparam int CB = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_in;
  logic        cfg_shift;
  logic        cfg_commit;
  logic        cfg_out;
  logic        cfg_ready;
  logic        cfg_err;
  logic        active_valid;
  logic [3:0]  leout;
  logic [15:0] lein;
  logic [15:0] drv;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] lein;
    logic [15:0] drv;
  } exp_t;

  typedef struct {
    int          cfg_id;
    logic [3:0]  leout;
    logic [15:0] lein;
    logic [15:0] drv;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  logic chain_bits[96];

  lei_xbar_cfg dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_in       (cfg_in),
    .cfg_shift    (cfg_shift),
    .cfg_commit   (cfg_commit),
    .cfg_out      (cfg_out),
    .cfg_ready    (cfg_ready),
    .cfg_err      (cfg_err),
    .active_valid (active_valid),
    .leout        (leout),
    .lein         (lein),
    .drv          (drv)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Config images. Unlisted fields hold 3'd7 (disabled).
  //   0: field0 = 2
  //   1: field f = f % 5 (value 4 is a disable code)
  //   2: field5 = 3, field6 = 4
  //   3: field0 = 1
  function automatic logic [47:0] make_cfg(input int id);
    logic [47:0] c;
    c = '1;
    case (id)
      0: c[2:0] = 3'd2;
      1: for (int f = 0; f < NF; f++) c[f*3 +: 3] = 3'(f % 5);
      2: begin
        c[17:15] = 3'd3;
        c[20:18] = 3'd4;
      end
      3: c[2:0] = 3'd1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Time for lein/drv to reflect the current leout and active config.
  task automatic settle_out();
`ifdef LEI_OUT_REG_EN
    step();
`else
    #1;
`endif
  endtask

  task automatic shift_bit(input logic b);
    en        = 1'b1;
    cfg_in    = b;
    cfg_shift = 1'b1;
    step();
    cfg_shift = 1'b0;
  endtask

  task automatic shift_n(input logic [47:0] c, input int first, input int count);
    for (int i = first; i < first + count; i++) shift_bit(c[i]);
  endtask

  task automatic commit();
    en         = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  // Expected routing is queued when leout is driven, then compared once
  // the output path has had time to respond.
  task automatic expect_route(input string nm, input logic [3:0] lv,
                              input logic [15:0] el, input logic [15:0] ed);
    exp_t e;
    leout  = lv;
    e.name = nm;
    e.lein = el;
    e.drv  = ed;
    sb.push_back(e);
    settle_out();
    e = sb.pop_front();
    $display("route %s leout=%b lein=%h drv=%h", e.name, leout, lein, drv);
    chk({e.name, "_lein"}, 32'(lein), 32'(e.lein));
    chk({e.name, "_drv"},  32'(drv),  32'(e.drv));
  endtask

  initial begin
    int cur_cfg;

    vecs[0] = '{0, 4'b0100, 16'h0001, 16'h0001};
    vecs[1] = '{0, 4'b1011, 16'h0000, 16'h0001};
    vecs[2] = '{0, 4'b1111, 16'h0001, 16'h0001};
    vecs[3] = '{0, 4'b0000, 16'h0000, 16'h0001};
    vecs[4] = '{1, 4'b0001, 16'h8421, 16'hBDEF};
    vecs[5] = '{1, 4'b0010, 16'h0842, 16'hBDEF};
    vecs[6] = '{1, 4'b0100, 16'h1084, 16'hBDEF};
    vecs[7] = '{1, 4'b1000, 16'h2108, 16'hBDEF};
    vecs[8] = '{1, 4'b1111, 16'hBDEF, 16'hBDEF};
    vecs[9] = '{1, 4'b0110, 16'h18C6, 16'hBDEF};

    rst        = 1'b1;
    en         = 1'b0;
    cfg_in     = 1'b0;
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
    leout      = 4'b1111;

    // Reset state
    #12;
    chk("rst_lein", 32'(lein), 32'h0);
    chk("rst_drv", 32'(drv), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_valid", 32'(active_valid), 32'h0);
    chk("rst_cfg_out", 32'(cfg_out), 32'h1);
    #10;
    rst = 1'b0;
    en  = 1'b1;
    step();

    // Table-driven routing vectors
    cur_cfg = -1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].cfg_id != cur_cfg) begin
        cur_cfg = vecs[i].cfg_id;
        shift_n(make_cfg(cur_cfg), 0, CB);
        chk("load_ready", 32'(cfg_ready), 32'h1);
        commit();
        chk("commit_err", 32'(cfg_err), 32'h0);
        chk("commit_valid", 32'(active_valid), 32'h1);
        chk("commit_ready", 32'(cfg_ready), 32'h0);
      end
      expect_route($sformatf("vec%0d", i), vecs[i].leout, vecs[i].lein, vecs[i].drv);
    end

    // Disable boundary: code 3 is the last slot, code 4 is disabled
    shift_n(make_cfg(2), 0, CB);
    commit();
    expect_route("boundary_hi", 4'b1000, 16'h0020, 16'h0020);
    expect_route("boundary_lo", 4'b0111, 16'h0000, 16'h0020);

    // Early commit after 47 bits is refused; the 48th bit makes it legal
    shift_n(make_cfg(3), 0, CB - 1);
    chk("early_ready_pre", 32'(cfg_ready), 32'h0);
    commit();
    chk("early_err", 32'(cfg_err), 32'h1);
    chk("early_ready", 32'(cfg_ready), 32'h0);
    chk("early_valid", 32'(active_valid), 32'h1);
    expect_route("early_keep", 4'b1000, 16'h0020, 16'h0020);
    shift_n(make_cfg(3), CB - 1, 1);
    chk("late_ready", 32'(cfg_ready), 32'h1);
    commit();
    chk("late_err", 32'(cfg_err), 32'h0);
    expect_route("late_route", 4'b0010, 16'h0001, 16'h0001);

    // Live reprogram: shifting does not disturb the active routing
    for (int i = 0; i < 30; i++) shift_bit(1'b1);
    expect_route("live_a", 4'b0010, 16'h0001, 16'h0001);
    expect_route("live_b", 4'b1101, 16'h0000, 16'h0001);
    cfg_in     = 1'b1;
    cfg_shift  = 1'b1;
    cfg_commit = 1'b1;
    step();
    cfg_shift  = 1'b0;
    cfg_commit = 1'b0;
    chk("shift_commit_err", 32'(cfg_err), 32'h1);
    expect_route("shift_commit_keep", 4'b0010, 16'h0001, 16'h0001);
    // 31 bits held; en=0 shifts must not count
    en        = 1'b0;
    cfg_shift = 1'b1;
    for (int i = 0; i < 10; i++) step();
    cfg_shift = 1'b0;
    en        = 1'b1;
    for (int i = 0; i < 16; i++) shift_bit(1'b1);
    chk("en_gate_ready47", 32'(cfg_ready), 32'h0);
    shift_bit(1'b1);
    chk("en_gate_ready48", 32'(cfg_ready), 32'h1);

    // Chain: after 48 shifts the first bit sits on cfg_out
    for (int i = 0; i < 96; i++) chain_bits[i] = 1'($urandom);
    for (int i = 0; i < 96; i++) begin
      if (i >= 48) chk($sformatf("chain_out%0d", i + 1), 32'(cfg_out), 32'(chain_bits[i-48]));
      shift_bit(chain_bits[i]);
    end
    chk("chain_ready", 32'(cfg_ready), 32'h1);

    // Reset in the middle of a stream, between clock edges
    for (int i = 0; i < 20; i++) shift_bit(1'b0);
    leout = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_lein", 32'(lein), 32'h0);
    chk("mid_rst_drv", 32'(drv), 32'h0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'h0);
    chk("mid_rst_err", 32'(cfg_err), 32'h0);
    chk("mid_rst_valid", 32'(active_valid), 32'h0);
    chk("mid_rst_cfg_out", 32'(cfg_out), 32'h1);
    #2;
    rst = 1'b0;
    step();
    shift_n(make_cfg(3), 0, CB - 1);
    chk("post_rst_ready47", 32'(cfg_ready), 32'h0);
    shift_n(make_cfg(3), CB - 1, 1);
    chk("post_rst_ready48", 32'(cfg_ready), 32'h1);
    commit();
    chk("post_rst_valid", 32'(active_valid), 32'h1);
    expect_route("post_rst_route", 4'b0010, 16'h0001, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_lei_xbar_cfg

// File: doc/lei_xbar_cfg.md
Name: lei_xbar_cfg

Overview:
Parametrised logic-element interconnect crossbar for the FPGA fabric. It routes any LE output slot to any LE input pin. Routing comes from a double-buffered configuration: a serial scan chain loads a shadow register, and an explicit commit copies it to the active register. The active set can be reprogrammed while routing stays live, and a chain output lets multiple tiles share one config stream.

Parameters:
NUM_LE, 2, number of logic elements served
OUTS_PER_LE, 2, outputs per LE; NUM_SLOTS = NUM_LE*OUTS_PER_LE (sources and destination buses)
LE_INPUTS, 4, input pins per destination slot
SEL_W, $clog2(NUM_SLOTS)+1, select field width; extra MSB gives disable codes
CFG_BITS, NUM_SLOTS*LE_INPUTS*SEL_W, total config length (derived, not overridden)

Ports:
clk  in  1  fabric clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  tile enable; gates shift and commit
cfg_in  in  1  serial config data
cfg_shift  in  1  shift one bit this cycle
cfg_commit  in  1  commit request, single-cycle pulse
cfg_out  out  1  serial chain output (shadow bit 0)
cfg_ready  out  1  shadow holds exactly CFG_BITS fresh bits
cfg_err  out  1  sticky: commit rejected
active_valid  out  1  at least one commit has been accepted since reset
leout  in  NUM_SLOTS  LE outputs, slot s = LE s/OUTS_PER_LE, output s%OUTS_PER_LE
lein  out  NUM_SLOTS*LE_INPUTS  routed LE inputs, bit s*LE_INPUTS+k
drv  out  NUM_SLOTS*LE_INPUTS  1 = pin k of slot s is driven by the crossbar

Behaviour:
- Field f = s*LE_INPUTS+k sits in active[f*SEL_W +: SEL_W].
  - Value < NUM_SLOTS: lein[f] = leout[value], drv[f] = 1.
  - Otherwise: lein[f] = 0, drv[f] = 0.
- Reset, asynchronous:
  - shadow and active go to all-ones (every field disabled), so lein = 0 and drv = 0 immediately.
  - bit_cnt = 0, state IDLE; cfg_ready, cfg_err and active_valid go to 0.
  - cfg_out = 1 (shadow bit 0 is all-ones).
- Shift on a clk edge with en & cfg_shift:
  - shadow <= {cfg_in, shadow[CFG_BITS-1:1]}.
  - bit_cnt increments and saturates at CFG_BITS.
  - The first bit shifted in lands in bit 0 after CFG_BITS shifts.
  - Extra shifts keep shifting; older bits leave through cfg_out.
- FSM, derived from bit_cnt:
  - IDLE (cnt=0) -> SHIFTING on the first shift.
  - SHIFTING -> FULL when cnt reaches CFG_BITS.
  - FULL stays FULL on further shifts.
  - Any state -> IDLE on an accepted commit.
  - cfg_ready = (state==FULL).
- Commit on a clk edge with en & cfg_commit & !cfg_shift:
  - If FULL: active <= shadow, active_valid <= 1, cfg_err <= 0, bit_cnt <= 0; shadow keeps its contents.
  - Otherwise: active unchanged, cfg_err <= 1.
- Shift and commit in the same cycle: the shift is performed, the commit is rejected, and cfg_err <= 1.
- en=0: shift and commit are ignored; routing stays live and unchanged.
- Routing latency: combinational from leout to lein. New routing takes effect in the cycle after the accepting edge.
- Shifting never disturbs the active routing (double-buffered).

Optional Feature:
LEI_OUT_REG_EN
- Defined: lein and drv are registered on clk, giving 1-cycle latency from leout and 2 cycles from commit. Both reset to 0 asynchronously.
- Undefined: purely combinational output path as described above.

Decomposition:
- Package lei_pkg holds:
  - sel-width function;
  - field-offset function f*SEL_W;
  - cfg FSM enum {IDLE, SHIFTING, FULL};
  - LEI_DISABLE constant (all-ones).
- Sub-module lei_route_mux: one per destination pin. Inputs are a SEL_W select and the leout vector; outputs are lein bit and drv bit, including the disable decode.
- Top level contains the shadow, active, counter, FSM and a generate loop of NUM_SLOTS*LE_INPUTS muxes.

Test Plan:
- Defaults (NUM_SLOTS=4, LE_INPUTS=4, SEL_W=3, CFG_BITS=48).
- Reset: pulse rst mid-cycle -> lein=0, drv=0, cfg_ready=0, cfg_err=0, active_valid=0, cfg_out=1 with no clock edge needed.
- Load: shift 48 bits with field0=3'd2 and all others 3'd7, then commit.
  - Next cycle: drv=16'h0001; leout=4'b0100 -> lein=16'h0001; leout=4'b1011 -> lein=0.
- Disable boundary: field5=3'd3 and field6=3'd4, commit, leout=4'b1000 -> lein[5]=1, drv[5]=1, lein[6]=0, drv[6]=0.
- Early commit: 47 shifts then commit -> cfg_err=1, cfg_ready=0, active unchanged. One more shift then commit -> accepted, cfg_err=0.
- Live reprogram: after a valid config, shift 30 bits and toggle leout -> routing unchanged. Assert cfg_commit with cfg_shift high -> cfg_err=1. en=0 during 10 shift cycles -> bit_cnt unchanged.
- Chain: shift 96 bits -> the first 48 bits appear on cfg_out in order starting at shift 49. Assert rst mid-stream -> bit_cnt=0 and all fields disabled.
